// File: rtl/pong_pkg.sv
// Shared definitions for the Pong ball block: FSM state encoding,
// RGB565 colour constants and the default active-video geometry.
package pong_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MOVE = 2'd1,
    ST_MISS = 2'd2
  } ball_state_e;

  localparam logic [15:0] RGB_BLACK = 16'h0000;
  localparam logic [15:0] RGB_WHITE = 16'hFFFF;
  localparam logic [15:0] RGB_RED   = 16'hF800;
  localparam logic [15:0] RGB_GREEN = 16'h07E0;
  localparam logic [15:0] RGB_BLUE  = 16'h001F;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

endpackage

// File: rtl/pong_ball_render.sv
// Two-stage ball pixel pipeline: stage 1 registers the pixel offset inside
// the sprite box, stage 2 applies the optional circular mask and colour.
module pong_ball_render
  import pong_pkg::*;
#(
  parameter int          BALL_SIZE = 16,
  parameter bit          ROUND     = 1'b0,
  parameter logic [15:0] COLOR     = RGB_WHITE
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [9:0]  pix_x_i,
  input  logic [9:0]  pix_y_i,
  input  logic [9:0]  ball_x_i,
  input  logic [9:0]  ball_y_i,
  output logic [15:0] pix_data_o
);

  localparam int OW = $clog2(BALL_SIZE);
  localparam int DW = OW + 2;
  localparam logic [9:0] SZ10 = 10'(BALL_SIZE);

  logic signed [10:0] ox_full, oy_full;
  logic               in_box;
  logic [OW-1:0]      ox_q, oy_q;
  logic               in_box_q;
  logic               mask;
  logic [15:0]        pix_data_d, pix_data_q;

  assign ox_full = $signed({1'b0, pix_x_i}) - $signed({1'b0, ball_x_i});
  assign oy_full = $signed({1'b0, pix_y_i}) - $signed({1'b0, ball_y_i});
  assign in_box  = !ox_full[10] && (ox_full[9:0] < SZ10) &&
                   !oy_full[10] && (oy_full[9:0] < SZ10);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ox_q       <= '0;
      oy_q       <= '0;
      in_box_q   <= 1'b0;
      pix_data_q <= '0;
    end else begin
      ox_q       <= ox_full[OW-1:0];
      oy_q       <= oy_full[OW-1:0];
      in_box_q   <= in_box;
      pix_data_q <= pix_data_d;
    end
  end

  generate
    if (ROUND) begin : g_round
      // Pixel centres in doubled coordinates, so the test stays exact in integers.
      logic signed [DW-1:0]   dx, dy;
      logic signed [2*DW-1:0] dx2, dy2;
      logic [2*DW:0]          r2;
      assign dx   = $signed({1'b0, ox_q, 1'b1}) - $signed(DW'(BALL_SIZE));
      assign dy   = $signed({1'b0, oy_q, 1'b1}) - $signed(DW'(BALL_SIZE));
      assign dx2  = dx * dx;
      assign dy2  = dy * dy;
      assign r2   = {1'b0, dx2} + {1'b0, dy2};
      assign mask = (r2 <= (2*DW+1)'(BALL_SIZE * BALL_SIZE));
    end else begin : g_square
      logic unused_offsets;
      assign unused_offsets = ^{ox_q, oy_q};
      assign mask = 1'b1;
    end
  endgenerate

  always_comb begin
    pix_data_d = RGB_BLACK;
    if (in_box_q && mask) pix_data_d = COLOR;
  end

  assign pix_data_o = pix_data_q;

endmodule

// File: rtl/pong_ball_engine.sv
// Pong ball block: per-frame motion with wall/paddle bounces and miss
// detection, a serve/miss sequencer, and the ball sprite renderer.
module pong_ball_engine
  import pong_pkg::*;
#(
  parameter int          H_ACTIVE    = H_ACTIVE_DEF,
  parameter int          V_ACTIVE    = V_ACTIVE_DEF,
  parameter int          BALL_SIZE   = 16,
  parameter int          SPEED_X     = 4,
  parameter int          SPEED_Y     = 3,
  parameter int          PAD_X       = 16,
  parameter int          PAD_W       = 8,
  parameter int          PAD_H       = 64,
  parameter int          MISS_FRAMES = 60,
  parameter bit          ROUND       = 1'b0,
  parameter logic [15:0] COLOR       = RGB_WHITE
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        frame_tick,
  input  logic        serve,
  input  logic [9:0]  pad_l_y,
  input  logic [9:0]  pad_r_y,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  output logic [15:0] pix_data,
  output logic [9:0]  ball_x,
  output logic [9:0]  ball_y,
  output logic [1:0]  state,
  output logic        miss_l,
  output logic        miss_r
);

  localparam int CW = $clog2(MISS_FRAMES + 1);

  localparam logic [9:0]         X_CENTRE = 10'((H_ACTIVE - BALL_SIZE) / 2);
  localparam logic [9:0]         Y_CENTRE = 10'((V_ACTIVE - BALL_SIZE) / 2);
  localparam logic signed [11:0] SPD_X    = 12'(SPEED_X);
  localparam logic signed [11:0] SPD_Y    = 12'(SPEED_Y);
  localparam logic signed [11:0] SZ       = 12'(BALL_SIZE);
  localparam logic signed [11:0] X_MAX    = 12'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [11:0] Y_MAX    = 12'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [11:0] LF       = 12'(PAD_X + PAD_W);
  localparam logic signed [11:0] RF       = 12'(H_ACTIVE - PAD_X - PAD_W);
  localparam logic signed [11:0] ZERO     = 12'sd0;
  localparam logic [CW-1:0]      CNT_END  = CW'(MISS_FRAMES);

  ball_state_e   state_q, state_d;
  logic [9:0]    x_q, x_d, y_q, y_d;
  logic          dir_x_q, dir_x_d;      // 1 = right
  logic          dir_y_q, dir_y_d;      // 1 = down
  logic          serve_dir_q, serve_dir_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          miss_l_q, miss_l_d, miss_r_q, miss_r_d;

  logic signed [11:0] sx, sy, nx, ny;
  logic [11:0]        y_top, y_bot, pl_top, pl_bot, pr_top, pr_bot;
  logic               ov_l, ov_r, hit_l, hit_r;

  assign sx = $signed({2'b00, x_q});
  assign sy = $signed({2'b00, y_q});
  assign nx = dir_x_q ? sx + SPD_X : sx - SPD_X;
  assign ny = dir_y_q ? sy + SPD_Y : sy - SPD_Y;

  // Paddle overlap is judged on the pre-move row span.
  assign y_top  = {2'b00, y_q};
  assign y_bot  = y_top + 12'(BALL_SIZE);
  assign pl_top = {2'b00, pad_l_y};
  assign pl_bot = pl_top + 12'(PAD_H);
  assign pr_top = {2'b00, pad_r_y};
  assign pr_bot = pr_top + 12'(PAD_H);
  assign ov_l   = (y_top < pl_bot) && (pl_top < y_bot);
  assign ov_r   = (y_top < pr_bot) && (pr_top < y_bot);

  assign hit_l = !dir_x_q && (nx <= LF) && (sx >= LF) && ov_l;
  assign hit_r = dir_x_q && ((nx + SZ) >= RF) && ((sx + SZ) <= RF) && ov_r;

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    dir_x_d     = dir_x_q;
    dir_y_d     = dir_y_q;
    serve_dir_d = serve_dir_q;
    cnt_d       = cnt_q;
    miss_l_d    = 1'b0;
    miss_r_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (serve) begin
          dir_x_d = serve_dir_q;
          dir_y_d = 1'b1;
          state_d = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (frame_tick) begin
          if (ny < ZERO) begin
            y_d     = '0;
            dir_y_d = 1'b1;
          end else if (ny > Y_MAX) begin
            y_d     = Y_MAX[9:0];
            dir_y_d = 1'b0;
          end else begin
            y_d = ny[9:0];
          end
          if (hit_l) begin
            x_d     = LF[9:0];
            dir_x_d = 1'b1;
          end else if (hit_r) begin
            x_d     = 10'(RF - SZ);
            dir_x_d = 1'b0;
          end else if ((nx < ZERO) || (nx > X_MAX)) begin
            // Ball leaves the field: freeze where it was and serve to the loser.
            miss_l_d    = (nx < ZERO);
            miss_r_d    = (nx > X_MAX);
            serve_dir_d = (nx > X_MAX);
            cnt_d       = '0;
            state_d     = ST_MISS;
            y_d         = y_q;
            dir_y_d     = dir_y_q;
          end else begin
            x_d = nx[9:0];
          end
        end
      end
      ST_MISS: begin
        if (frame_tick) begin
          if (cnt_inc == CNT_END) begin
            cnt_d   = '0;
            x_d     = X_CENTRE;
            y_d     = Y_CENTRE;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt_inc;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      x_q         <= X_CENTRE;
      y_q         <= Y_CENTRE;
      dir_x_q     <= 1'b1;
      dir_y_q     <= 1'b1;
      serve_dir_q <= 1'b1;
      cnt_q       <= '0;
      miss_l_q    <= 1'b0;
      miss_r_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      dir_x_q     <= dir_x_d;
      dir_y_q     <= dir_y_d;
      serve_dir_q <= serve_dir_d;
      cnt_q       <= cnt_d;
      miss_l_q    <= miss_l_d;
      miss_r_q    <= miss_r_d;
    end
  end

  assign ball_x = x_q;
  assign ball_y = y_q;
  assign state  = state_q;
  assign miss_l = miss_l_q;
  assign miss_r = miss_r_q;

  pong_ball_render #(
    .BALL_SIZE (BALL_SIZE),
    .ROUND     (ROUND),
    .COLOR     (COLOR)
  ) u_render (
    .clk_i      (vga_clk),
    .rst_i      (sys_rst),
    .pix_x_i    (pix_x),
    .pix_y_i    (pix_y),
    .ball_x_i   (x_q),
    .ball_y_i   (y_q),
    .pix_data_o (pix_data)
  );

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed bench for pong_ball_engine: expectations are queued with a due
// cycle and a negedge monitor pops and compares them against the DUT.
module tb_pong_ball_engine;

  logic        vga_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        serve = 1'b0;
  logic [9:0]  pad_l_y = '0;
  logic [9:0]  pad_r_y = '0;
  logic [9:0]  pix_x = '0;
  logic [9:0]  pix_y = '0;

  logic [15:0] pix_data, pix_data_r;
  logic [9:0]  ball_x, ball_y, ball_x_r, ball_y_r;
  logic [1:0]  state, state_r;
  logic        miss_l, miss_r, miss_l_r, miss_r_r;

  always #5 vga_clk = ~vga_clk;

  pong_ball_engine dut (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .frame_tick(frame_tick), .serve(serve),
    .pad_l_y(pad_l_y), .pad_r_y(pad_r_y), .pix_x(pix_x), .pix_y(pix_y),
    .pix_data(pix_data), .ball_x(ball_x), .ball_y(ball_y), .state(state),
    .miss_l(miss_l), .miss_r(miss_r)
  );

  pong_ball_engine #(.ROUND(1'b1)) dut_round (
    .vga_clk(vga_clk), .sys_rst(sys_rst), .frame_tick(frame_tick), .serve(serve),
    .pad_l_y(pad_l_y), .pad_r_y(pad_r_y), .pix_x(pix_x), .pix_y(pix_y),
    .pix_data(pix_data_r), .ball_x(ball_x_r), .ball_y(ball_y_r), .state(state_r),
    .miss_l(miss_l_r), .miss_r(miss_r_r)
  );

  typedef struct {
    int          due;
    int          fld;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  localparam int F_X = 0, F_Y = 1, F_ST = 2, F_ML = 3, F_MR = 4, F_PSQ = 5, F_PRD = 6;

  always @(posedge vga_clk) cyc <= cyc + 1;

  function automatic logic [15:0] observe(input int fld);
    case (fld)
      F_X:     return {6'd0, ball_x};
      F_Y:     return {6'd0, ball_y};
      F_ST:    return {14'd0, state};
      F_ML:    return {15'd0, miss_l};
      F_MR:    return {15'd0, miss_r};
      F_PSQ:   return pix_data;
      default: return pix_data_r;
    endcase
  endfunction

  function automatic string fname(input int fld);
    case (fld)
      F_X:     return "ball_x";
      F_Y:     return "ball_y";
      F_ST:    return "state";
      F_ML:    return "miss_l";
      F_MR:    return "miss_r";
      F_PSQ:   return "pix_square";
      default: return "pix_round";
    endcase
  endfunction

  always @(negedge vga_clk) begin : monitor
    exp_t        e;
    logic [15:0] got;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e   = sb.pop_front();
      got = observe(e.fld);
      n_checks++;
      if (got !== e.val) begin
        n_errors++;
        $display("FAIL %s cyc=%0d got=%h want=%h", fname(e.fld), cyc, got, e.val);
      end else begin
        $display("check %s cyc=%0d value=%h ok", fname(e.fld), cyc, got);
      end
    end
  end

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic expect_at(input int fld, input int val, input int dly);
    exp_t e;
    e.due = cyc + dly;
    e.fld = fld;
    e.val = 16'(val);
    sb.push_back(e);
  endtask

  task automatic check_ball(input int x, input int y, input int st);
    expect_at(F_X, x, 0);
    expect_at(F_Y, y, 0);
    expect_at(F_ST, st, 0);
  endtask

  task automatic tick();
    step();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic serve_go();
    step();
    serve = 1'b1;
    step();
    serve = 1'b0;
  endtask

  task automatic do_reset();
    step();
    sys_rst = 1'b1;
    step();
    step();
    sys_rst = 1'b0;
    step();
  endtask

  task automatic pixel(input int px, input int py, input int sq, input int rd);
    step();
    pix_x = 10'(px);
    pix_y = 10'(py);
    expect_at(F_PSQ, sq, 2);
    expect_at(F_PRD, rd, 2);
  endtask

  initial begin
    repeat (3) step();
    sys_rst = 1'b0;
    step();
    check_ball(312, 232, 0);
    expect_at(F_ML, 0, 0);
    expect_at(F_MR, 0, 0);
    expect_at(F_PSQ, 0, 0);
    expect_at(F_PRD, 0, 0);

    // Idle frames leave the ball parked in the centre.
    repeat (5) begin
      tick();
      check_ball(312, 232, 0);
      expect_at(F_ML, 0, 0);
      expect_at(F_MR, 0, 0);
    end

    // Serve coinciding with frame_tick: no motion until the next tick.
    step();
    serve = 1'b1;
    frame_tick = 1'b1;
    step();
    serve = 1'b0;
    frame_tick = 1'b0;
    check_ball(312, 232, 1);
    tick();
    check_ball(316, 235, 1);
    serve_go();
    expect_at(F_ST, 1, 0);
    tick();
    check_ball(320, 238, 1);

    // Reset together with frame_tick wins.
    step();
    sys_rst = 1'b1;
    frame_tick = 1'b1;
    step();
    sys_rst = 1'b0;
    frame_tick = 1'b0;
    check_ball(312, 232, 0);

    // Right paddle hit at tick 72, bottom wall at tick 78.
    pad_r_y = 10'd420;
    serve_go();
    for (int k = 1; k <= 79; k++) begin
      tick();
      case (k)
        71: check_ball(596, 445, 1);
        72: check_ball(600, 448, 1);
        73: check_ball(596, 451, 1);
        77: check_ball(580, 463, 1);
        78: check_ball(576, 464, 1);
        79: check_ball(572, 461, 1);
        default: ;
      endcase
    end
    do_reset();

    // Paddle out of the way: miss on the right at tick 79.
    pad_r_y = 10'd0;
    serve_go();
    for (int k = 1; k <= 79; k++) begin
      tick();
      case (k)
        72: check_ball(600, 448, 1);
        73: check_ball(604, 451, 1);
        78: check_ball(624, 464, 1);
        79: begin
          check_ball(624, 464, 2);
          expect_at(F_MR, 1, 0);
          expect_at(F_ML, 0, 0);
          expect_at(F_MR, 0, 1);
        end
        default: ;
      endcase
    end
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (k == 59) check_ball(624, 464, 2);
      if (k == 60) check_ball(312, 232, 0);
    end
    serve_go();
    tick();
    check_ball(316, 235, 1);
    do_reset();

    // Reset lands on the tick that would have produced miss_r.
    serve_go();
    repeat (78) tick();
    check_ball(624, 464, 1);
    step();
    sys_rst = 1'b1;
    frame_tick = 1'b1;
    step();
    sys_rst = 1'b0;
    frame_tick = 1'b0;
    check_ball(312, 232, 0);
    expect_at(F_MR, 0, 0);
    expect_at(F_ML, 0, 0);
    expect_at(F_MR, 0, 1);

    // Sprite rendering with the ball at (312,232).
    pixel(312, 232, 16'hFFFF, 16'h0000);
    pixel(328, 232, 16'h0000, 16'h0000);
    pixel(320, 240, 16'hFFFF, 16'hFFFF);
    pixel(327, 247, 16'hFFFF, 16'h0000);
    pixel(311, 232, 16'h0000, 16'h0000);
    pixel(312, 248, 16'h0000, 16'h0000);
    pixel(313, 236, 16'hFFFF, 16'hFFFF);
    pixel(320, 232, 16'hFFFF, 16'hFFFF);
    pixel(327, 239, 16'hFFFF, 16'hFFFF);

    for (int i = 0; i < 50 && sb.size() > 0; i++) step();
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain pending=%0d want=0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
